// File: rtl/irq_trap_seq_pkg.sv
// Shared definitions for the machine-level interrupt trap sequencer: cause codes,
// mtvec mode encodings, FSM state type and the source priority encoder.
package irq_trap_seq_pkg;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBnd,
        StRedir,
        StHandler,
        StRet
    } trap_state_e;

    // pend is {ext, timer, sw}; machine priority is external > software > timer.
    function automatic logic [3:0] pick_cause(input logic [2:0] pend);
        if (pend[2]) begin
            return CAUSE_MEI;
        end
        if (pend[0]) begin
            return CAUSE_MSI;
        end
        return CAUSE_MTI;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-stage level synchroniser for an asynchronous input, cleared by the
// synchronous active-low reset.
module irq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/irq_trap_seq.sv
// Interrupt trap sequencer: masks synchronised interrupt lines, enters the trap at an
// instruction boundary (CSR strobes + PC redirect) and sequences mret back to mepc.
module irq_trap_seq
    import irq_trap_seq_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    input  logic            mstatus_mie,
    input  logic [2:0]      mie_bits,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_next_pc,
    input  logic            mret_valid,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    input  logic            redir_ready,
    output logic            mepc_we,
    output logic [XLEN-1:0] mepc_wdata,
    output logic            mcause_we,
    output logic [XLEN-1:0] mcause_wdata,
    output logic            mstatus_trap,
    output logic            mstatus_ret,
    output logic            in_handler
);

    trap_state_e     state_q, state_d;
    logic [3:0]      cause_q, cause_d;
    logic [XLEN-1:0] ret_pc_q, ret_pc_d;
    logic            ext_s;
    logic [2:0]      pend;

    irq_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ext_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(irq_ext),
        .sync_o (ext_s)
    );

    assign pend = {ext_s, irq_timer, irq_sw} & mie_bits & {3{mstatus_mie}};

    // Reserved mtvec modes fall back to direct.
    function automatic logic [XLEN-1:0] vec_target(input logic [XLEN-1:0] tvec,
                                                   input logic [3:0]      code);
        logic [XLEN-1:0] base;
        logic [XLEN-1:0] tgt;
        base = {tvec[XLEN-1:2], 2'b00};
        case (tvec[1:0])
            MTVEC_VECTORED: tgt = base + XLEN'({code, 2'b00});
            MTVEC_DIRECT:   tgt = base;
            default:        tgt = base;
        endcase
        return tgt;
    endfunction

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        ret_pc_d     = ret_pc_q;
        redir_valid  = 1'b0;
        redir_pc     = '0;
        mepc_we      = 1'b0;
        mepc_wdata   = '0;
        mcause_we    = 1'b0;
        mcause_wdata = '0;
        mstatus_trap = 1'b0;
        mstatus_ret  = 1'b0;
        in_handler   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|pend) begin
                    state_d = StWaitBnd;
                end
            end
            StWaitBnd: begin
                if (!(|pend)) begin
                    state_d = StIdle;
                end else if (commit_valid) begin
                    cause_d      = pick_cause(pend);
                    mepc_we      = 1'b1;
                    mepc_wdata   = commit_next_pc;
                    mcause_we    = 1'b1;
                    mcause_wdata = {1'b1, {(XLEN-5){1'b0}}, cause_d};
                    mstatus_trap = 1'b1;
                    state_d      = StRedir;
                end
            end
            StRedir: begin
                redir_valid = 1'b1;
                redir_pc    = vec_target(mtvec, cause_q);
                in_handler  = 1'b1;
                if (redir_ready) begin
                    state_d = StHandler;
                end
            end
            StHandler: begin
                in_handler = 1'b1;
                // commit_valid is deliberately ignored here, so mret wins on a shared cycle.
                if (mret_valid) begin
                    mstatus_ret = 1'b1;
                    ret_pc_d    = mepc;
                    state_d     = StRet;
                end
            end
            StRet: begin
                redir_valid = 1'b1;
                redir_pc    = ret_pc_q;
                in_handler  = 1'b1;
                if (redir_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // No strobe or redirect may escape while reset is being applied.
        if (!rst_n) begin
            redir_valid  = 1'b0;
            redir_pc     = '0;
            mepc_we      = 1'b0;
            mepc_wdata   = '0;
            mcause_we    = 1'b0;
            mcause_wdata = '0;
            mstatus_trap = 1'b0;
            mstatus_ret  = 1'b0;
            in_handler   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cause_q  <= '0;
            ret_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            ret_pc_q <= ret_pc_d;
        end
    end

endmodule

// File: tb/tb_irq_trap_seq.sv
// Self-checking bench for irq_trap_seq: a table of trap-entry vectors plus hand-written
// sequences for masking, backpressure, synchroniser latency, priority and reset.
module tb_irq_trap_seq;

    logic        clk;
    logic        rst_n;
    logic        irq_ext, irq_timer, irq_sw, mstatus_mie;
    logic [2:0]  mie_bits;
    logic [31:0] mtvec, mepc, commit_next_pc;
    logic        commit_valid, mret_valid, redir_ready;
    logic        redir_valid, mepc_we, mcause_we, mstatus_trap, mstatus_ret, in_handler;
    logic [31:0] redir_pc, mepc_wdata, mcause_wdata;

    irq_trap_seq #(
        .XLEN       (32),
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_ext       (irq_ext),
        .irq_timer     (irq_timer),
        .irq_sw        (irq_sw),
        .mstatus_mie   (mstatus_mie),
        .mie_bits      (mie_bits),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .commit_valid  (commit_valid),
        .commit_next_pc(commit_next_pc),
        .mret_valid    (mret_valid),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .redir_ready   (redir_ready),
        .mepc_we       (mepc_we),
        .mepc_wdata    (mepc_wdata),
        .mcause_we     (mcause_we),
        .mcause_wdata  (mcause_wdata),
        .mstatus_trap  (mstatus_trap),
        .mstatus_ret   (mstatus_ret),
        .in_handler    (in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mtvec;
        logic [2:0]  en;
        logic [2:0]  lines;  // {ext, timer, sw}
        logic [31:0] pc;
        logic [31:0] mcause;
        logic [31:0] target;
    } vec_t;

    typedef struct {
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] target;
    } exp_t;

    vec_t vecs[5];
    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Call while the DUT waits at a boundary; leaves it in the redirect state, ready low.
    task automatic enter_trap(input string tag, input logic [31:0] pc, input logic [31:0] mc,
                              input logic [31:0] tgt);
        exp_t e;
        commit_valid   = 1'b1;
        commit_next_pc = pc;
        sbq.push_back('{mcause: mc, mepc: pc, target: tgt});
        #1;
        chk1({tag, "_mepc_we"}, mepc_we, 1'b1);
        if (mepc_we && sbq.size() > 0) begin
            e = sbq[0];
            chk32({tag, "_mepc_wdata"}, mepc_wdata, e.mepc);
            chk32({tag, "_mcause_wdata"}, mcause_wdata, e.mcause);
        end
        chk1({tag, "_mcause_we"}, mcause_we, 1'b1);
        chk1({tag, "_mstatus_trap"}, mstatus_trap, 1'b1);
        tick();
        commit_valid = 1'b0;
        #1;
        chk1({tag, "_redir_valid"}, redir_valid, 1'b1);
        chk1({tag, "_strobe_1cyc"}, mepc_we | mcause_we | mstatus_trap, 1'b0);
        chk1({tag, "_in_handler"}, in_handler, 1'b1);
        if (redir_valid && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk32({tag, "_redir_pc"}, redir_pc, e.target);
        end
    endtask

    // Completes the trap redirect, runs mret to pc and returns to idle.
    task automatic leave_trap(input string tag, input logic [31:0] pc);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        #1;
        chk1({tag, "_handler_novalid"}, redir_valid, 1'b0);
        chk1({tag, "_handler_in"}, in_handler, 1'b1);
        mret_valid = 1'b1;
        mepc       = pc;
        #1;
        chk1({tag, "_mstatus_ret"}, mstatus_ret, 1'b1);
        tick();
        mret_valid = 1'b0;
        mepc       = 32'hDEAD_BEEF;
        #1;
        chk1({tag, "_ret_valid"}, redir_valid, 1'b1);
        chk32({tag, "_ret_pc"}, redir_pc, pc);
        chk1({tag, "_ret_1cyc"}, mstatus_ret, 1'b0);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        #1;
        chk1({tag, "_idle_in"}, in_handler, 1'b0);
        chk1({tag, "_idle_valid"}, redir_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst_n = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0; mstatus_mie = 1'b0;
        mie_bits = 3'b000; mtvec = 32'h0; mepc = 32'h0; commit_valid = 1'b0;
        commit_next_pc = 32'h0; mret_valid = 1'b0; redir_ready = 1'b0;

        vecs[0] = '{32'h0000_1000, 3'b010, 3'b010, 32'h200, 32'h8000_0007, 32'h0000_1000};
        vecs[1] = '{32'h0000_2001, 3'b111, 3'b111, 32'h344, 32'h8000_000B, 32'h0000_202C};
        vecs[2] = '{32'h0000_2001, 3'b011, 3'b111, 32'h348, 32'h8000_0003, 32'h0000_200C};
        vecs[3] = '{32'h0000_2001, 3'b010, 3'b010, 32'h34C, 32'h8000_0007, 32'h0000_201C};
        vecs[4] = '{32'hFFFF_FFFD, 3'b100, 3'b100, 32'h350, 32'h8000_000B, 32'h0000_0028};

        // Reset state with sources raised.
        irq_timer = 1'b1; mstatus_mie = 1'b1; mie_bits = 3'b111;
        tick();
        tick();
        chk1("reset_strobes", redir_valid | mepc_we | mcause_we | mstatus_trap | mstatus_ret
             | in_handler, 1'b0);
        chk32("reset_redir_pc", redir_pc, 32'h0);
        irq_timer = 1'b0; mstatus_mie = 1'b0;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            mtvec       = vecs[i].mtvec;
            mie_bits    = vecs[i].en;
            {irq_ext, irq_timer, irq_sw} = vecs[i].lines;
            mstatus_mie = 1'b1;
            tick(); tick(); tick();
            enter_trap($sformatf("vec%0d", i), vecs[i].pc, vecs[i].mcause, vecs[i].target);
            {irq_ext, irq_timer, irq_sw} = 3'b000;
            mstatus_mie = 1'b0;
            leave_trap($sformatf("vec%0d", i), vecs[i].pc);
        end

        // Globally masked: no trap however many boundaries pass.
        mtvec = 32'h1000; mie_bits = 3'b111; mstatus_mie = 1'b0; irq_sw = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            commit_valid = i[0];
            tick();
            if (mepc_we || mcause_we || mstatus_trap || redir_valid) bad++;
        end
        commit_valid = 1'b0; irq_sw = 1'b0;
        chk32("mask_no_trap", 32'(bad), 32'd0);

        // One-cycle pulse drops before the boundary arrives.
        mstatus_mie = 1'b1; mie_bits = 3'b001; irq_sw = 1'b1;
        tick();
        irq_sw = 1'b0; commit_valid = 1'b1; commit_next_pc = 32'h500;
        #1;
        chk1("pulse_no_strobe", mepc_we, 1'b0);
        tick();
        tick();
        chk1("pulse_no_redir", redir_valid | mepc_we, 1'b0);
        commit_valid = 1'b0;

        // Redirect backpressure, mret racing a commit, then return with backpressure.
        mie_bits = 3'b010; irq_timer = 1'b1;
        tick(); tick();
        enter_trap("bp", 32'h200, 32'h8000_0007, 32'h1000);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!redir_valid || redir_pc !== 32'h1000 || !in_handler) bad++;
        end
        chk32("bp_stable", 32'(bad), 32'd0);
        irq_timer = 1'b0; mstatus_mie = 1'b0;
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        mret_valid = 1'b1; commit_valid = 1'b1; commit_next_pc = 32'h999; mepc = 32'h200;
        #1;
        chk1("mret_wins_ret", mstatus_ret, 1'b1);
        chk1("mret_wins_no_trap", mepc_we, 1'b0);
        tick();
        mret_valid = 1'b0; commit_valid = 1'b0; mepc = 32'h0;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (!redir_valid || redir_pc !== 32'h200 || !in_handler) bad++;
            tick();
        end
        chk32("ret_bp_stable", 32'(bad), 32'd0);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk1("ret_in_handler_fall", in_handler, 1'b0);

        // mret outside the handler is ignored.
        mret_valid = 1'b1; mepc = 32'h555;
        #1;
        chk1("stray_mret_ret", mstatus_ret, 1'b0);
        tick();
        mret_valid = 1'b0;
        chk1("stray_mret_redir", redir_valid | in_handler, 1'b0);

        // Synchroniser latency with commits every cycle and ready held high.
        mie_bits = 3'b100; mstatus_mie = 1'b1; commit_valid = 1'b1;
        commit_next_pc = 32'h400; redir_ready = 1'b1;
        irq_ext = 1'b1;
        #1;
        chk1("sync_e0", mepc_we, 1'b0);
        tick();
        chk1("sync_e1", mepc_we, 1'b0);
        tick();
        chk1("sync_e2", mepc_we, 1'b0);
        tick();
        chk1("sync_e3", mepc_we, 1'b1);
        chk32("sync_mcause", mcause_wdata, 32'h8000_000B);
        chk32("sync_mepc", mepc_wdata, 32'h400);
        tick();
        chk1("sync_redir_valid", redir_valid, 1'b1);
        chk32("sync_redir_pc", redir_pc, 32'h1000);
        irq_ext = 1'b0; mstatus_mie = 1'b0; commit_valid = 1'b0;
        tick();
        chk1("ready_high_1cyc", redir_valid, 1'b0);
        mret_valid = 1'b1; mepc = 32'h400;
        tick();
        mret_valid = 1'b0;
        chk32("ready_high_ret_pc", redir_pc, 32'h400);
        tick();
        chk1("ready_high_idle", in_handler | redir_valid, 1'b0);
        redir_ready = 1'b0;

        // Two pending sources: software first, timer taken after mret.
        mtvec = 32'h2001; mie_bits = 3'b111; mstatus_mie = 1'b1;
        irq_sw = 1'b1; irq_timer = 1'b1;
        tick(); tick();
        enter_trap("mp1", 32'h600, 32'h8000_0003, 32'h200C);
        irq_sw = 1'b0; mstatus_mie = 1'b0;
        leave_trap("mp1", 32'h600);
        mstatus_mie = 1'b1;
        tick(); tick();
        enter_trap("mp2", 32'h604, 32'h8000_0007, 32'h201C);
        irq_timer = 1'b0; mstatus_mie = 1'b0;
        leave_trap("mp2", 32'h604);

        // Reset while the trap redirect is outstanding.
        mtvec = 32'h1000; mie_bits = 3'b010; mstatus_mie = 1'b1; irq_timer = 1'b1;
        tick(); tick();
        enter_trap("rst", 32'h700, 32'h8000_0007, 32'h1000);
        rst_n = 1'b0; irq_timer = 1'b0; mstatus_mie = 1'b0;
        tick();
        chk1("rst_mid_outputs", redir_valid | mepc_we | mcause_we | mstatus_trap | mstatus_ret
             | in_handler, 1'b0);
        chk32("rst_mid_redir_pc", redir_pc, 32'h0);
        rst_n = 1'b1;
        tick();
        chk1("rst_after_idle", redir_valid | in_handler, 1'b0);

        chk32("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_trap_seq.md
Name: irq_trap_seq

Overview:
- Core-side consumer of machine-level interrupt lines (external, timer, software) raised by the interrupt controller.
- Synchronises and masks the requests, waits for an instruction boundary, and performs trap entry: PC redirect plus mepc/mcause/mstatus update strobes to the CSR file.
- Sequences mret back to the saved PC.
- Sits between the interrupt controller, the CSR register file and the fetch/commit stages.

Parameters:
- XLEN, 32, data/address width
- SYNC_STAGES, 2, synchroniser depth on irq_ext (async source); valid range 2..3

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- irq_ext  in  1  external interrupt, level, asynchronous
- irq_timer  in  1  timer interrupt, level, clk-synchronous
- irq_sw  in  1  software interrupt, level, clk-synchronous
- mstatus_mie  in  1  global machine interrupt enable from CSR file
- mie_bits  in  3  per-source enable {MEIE, MTIE, MSIE}
- mtvec  in  XLEN  trap vector; [1:0] is mode (0 = direct, 1 = vectored)
- mepc  in  XLEN  current mepc CSR value, used for mret
- commit_valid  in  1  an instruction retires this cycle
- commit_next_pc  in  XLEN  PC of the next instruction to execute
- mret_valid  in  1  mret retires this cycle
- redir_valid  out  1  PC redirect request to fetch
- redir_pc  out  XLEN  redirect target
- redir_ready  in  1  fetch accepts redirect
- mepc_we  out  1  mepc write strobe
- mepc_wdata  out  XLEN  value to write to mepc
- mcause_we  out  1  mcause write strobe
- mcause_wdata  out  XLEN  value to write to mcause
- mstatus_trap  out  1  strobe to CSR file: MPIE <= MIE, MIE <= 0
- mstatus_ret  out  1  strobe to CSR file: MIE <= MPIE, MPIE <= 1
- in_handler  out  1  high from trap entry until mret accepted

Behaviour:
- Clock and reset:
  - Reset rst_n, synchronous, active-low; clock clk.
  - In reset: every output is 0, state is IDLE, synchroniser flops and latched cause are cleared.
  - Reset asserted in any state, including mid-handshake, returns the block to IDLE next edge with no CSR strobe.
- Input conditioning:
  - irq_ext passes through SYNC_STAGES flops.
  - pend = {ext_s, timer, sw} & mie_bits & {3{mstatus_mie}}.
- Priority and cause encoding (RISC-V machine priority):
  - external: code 11
  - software: code 3
  - timer: code 7
  - mcause_wdata = {1'b1, (XLEN-5) zeros, code[3:0]}.
- Vector target:
  - direct: {mtvec[XLEN-1:2], 2'b00}
  - vectored: {mtvec[XLEN-1:2], 2'b00} + 4*code, modulo 2^XLEN (wrap ignored)
- States:
  - IDLE: if pend != 0, go to WAIT_BND.
  - WAIT_BND: level-sensitive.
    - If pend == 0, return to IDLE with no trap.
    - On commit_valid && pend != 0: latch cause from pend in that cycle and latch commit_next_pc. In the same cycle pulse mepc_we, mcause_we and mstatus_trap for exactly 1 cycle, with mepc_wdata = commit_next_pc. Go to REDIR.
  - REDIR:
    - redir_valid = 1, redir_pc = vector target.
    - Hold both stable until redir_ready; on the redir_ready cycle go to HANDLER.
    - in_handler rises on entry to REDIR.
  - HANDLER:
    - No nesting: interrupts are ignored because mstatus_mie is 0.
    - On mret_valid: pulse mstatus_ret for 1 cycle, go to RET.
  - RET:
    - redir_valid = 1, redir_pc = mepc sampled on the mret cycle.
    - On redir_ready: go to IDLE, in_handler falls.
- Latency: commit boundary to redir_valid is 1 cycle. With irq_ext, the 2-flop synchroniser adds 2 cycles before pend.
- Boundary conditions:
  - Simultaneous commit_valid and mret_valid in HANDLER: mret wins.
  - mret_valid outside HANDLER: ignored.
  - Multiple pending sources: highest priority is taken; the others remain pending for after mret.
  - redir_ready held high: each redirect completes in 1 cycle.

Decomposition:
- Shared package holds:
  - cause codes: CAUSE_MEI = 11, CAUSE_MSI = 3, CAUSE_MTI = 7
  - mtvec mode encodings
  - state enum: IDLE, WAIT_BND, REDIR, HANDLER, RET
- One sub-module: irq_sync, an N-stage reset-cleared synchroniser instanced for irq_ext.

Test Plan:
- Timer entry, direct mode: mtvec = 0x0000_1000, mstatus_mie = 1, mie_bits = 3'b010. Raise irq_timer; commit_valid with next_pc = 0x200. -> Same cycle: mepc_wdata = 0x200, mcause_wdata = 0x8000_0007, mstatus_trap pulse. Next cycle: redir_pc = 0x1000.
- Vectored mode with priority: mtvec = 0x0000_2001, all three lines high, all enabled. -> mcause = 0x8000_000B, redir_pc = 0x202C.
- Masking and level drop:
  - mstatus_mie = 0 with irq_sw high for 20 cycles -> no strobes, redir_valid stays 0.
  - irq_sw pulsed for 1 cycle while commit_valid is low -> return to IDLE, no trap.
- Redirect backpressure and return: redir_ready held low 5 cycles -> redir_valid and redir_pc stable throughout; then mret_valid with mepc = 0x200 -> mstatus_ret pulse, redir_pc = 0x200, in_handler falls after ready.
- Synchroniser latency: irq_ext rises with commit_valid held high -> mepc_we appears on the 3rd edge after the rise (2 sync cycles + boundary), not earlier.
- Reset mid-REDIR: rst_n low for 1 cycle -> all outputs 0 next edge; state IDLE, in_handler 0.
